// File: rtl/pwm_cmd_pkg.sv
// ---------------------------------------------------------------------------
// pwm_cmd_pkg : state codes, link ASCII constants and code->ASCII mapping
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_IDLE      = 3'd1,
    CMD_PRELOAD   = 3'd2,
    CMD_DELIVERY  = 3'd3,
    CMD_TOP       = 3'd4,
    CMD_INCREMENT = 3'd5,
    CMD_DECREMENT = 3'd6,
    CMD_RSVD      = 3'd7
  } cmd_code_e;

  typedef enum logic [1:0] {
    H_IDLE     = 2'd0,
    H_SEND     = 2'd1,
    H_WAIT_TX  = 2'd2,
    H_WAIT_ACK = 2'd3
  } host_state_e;

  localparam logic [7:0] c_ascii_ack      = 8'h41;  // 'A'
  localparam logic [7:0] c_ascii_reached  = 8'h52;  // 'R'
  localparam logic [7:0] c_ascii_idle     = 8'h69;  // 'i'
  localparam logic [7:0] c_ascii_preload  = 8'h70;  // 'p'
  localparam logic [7:0] c_ascii_delivery = 8'h65;  // 'e'
  localparam logic [7:0] c_ascii_top      = 8'h74;  // 't'
  localparam logic [7:0] c_ascii_inc      = 8'h75;  // 'u'
  localparam logic [7:0] c_ascii_dec      = 8'h64;  // 'd'

  // 0x00 marks a code with no command byte
  function automatic logic [7:0] code_to_ascii(input logic [2:0] code);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      CMD_IDLE:      ch = c_ascii_idle;
      CMD_PRELOAD:   ch = c_ascii_preload;
      CMD_DELIVERY:  ch = c_ascii_delivery;
      CMD_TOP:       ch = c_ascii_top;
      CMD_INCREMENT: ch = c_ascii_inc;
      CMD_DECREMENT: ch = c_ascii_dec;
      default:       ch = 8'h00;
    endcase
    return ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_8n1_phy.sv
// ---------------------------------------------------------------------------
// uart_8n1_phy : 8N1 UART serializer/deserializer, LSB first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_8n1_phy #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_load_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW      = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] c_last    = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] c_half_m1 = CW'(BIT_CYC / 2 - 1);

  logic          tx_q, tx_busy_q, tx_done_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_shift_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (tx_load_i) begin
          tx_q       <= 1'b0;
          tx_shift_q <= {1'b1, tx_data_i};
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          tx_busy_q  <= 1'b1;
        end
      end else if (tx_cnt_q == c_last) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  logic [1:0]    rx_sync_q;
  logic          rx_prev_q, rx_busy_q, rx_valid_q, rx_ferr_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          w_rx_s;

  assign w_rx_s = rx_sync_q[1];

  // Bit 0 is the start bit, checked half a period in; later bits land mid-bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_i};
      rx_prev_q  <= w_rx_s;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !w_rx_s) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= '0;
          rx_bit_q  <= '0;
        end
      end else if (rx_bit_q == 4'd0) begin
        if (rx_cnt_q == c_half_m1) begin
          rx_cnt_q <= '0;
          if (w_rx_s) rx_busy_q <= 1'b0;
          else        rx_bit_q  <= 4'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      end else if (rx_cnt_q == c_last) begin
        rx_cnt_q <= '0;
        if (rx_bit_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_valid_q <= w_rx_s;
          rx_ferr_q  <= !w_rx_s;
        end else begin
          rx_shift_q <= {w_rx_s, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

  assign tx_o           = tx_q;
  assign tx_busy_o      = tx_busy_q;
  assign tx_done_o      = tx_done_q;
  assign rx_data_o      = rx_shift_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_ferr_q;

endmodule

`default_nettype wire

// File: rtl/pwm_cmd_host.sv
// ---------------------------------------------------------------------------
// pwm_cmd_host : host-side command initiator and reply parser for the PWM link
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_cmd_host
  import pwm_cmd_pkg::*;
#(
  parameter int CLK_HZ          = 27000000,
  parameter int BAUD            = 115200,
  parameter int ACK_TIMEOUT_CYC = 270000,
  parameter int MAX_RETRY       = 3,
  parameter int ALIVE_CYC       = 5400000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic [1:0] retry_cnt,
  input  logic       rx,
  output logic       tx,
  output logic       reached_pulse,
  output logic       state_valid,
  output logic [7:0] state_msg,
  output logic       link_alive
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT_CYC + 1);
  localparam int ALV_W = (ALIVE_CYC > 2) ? $clog2(ALIVE_CYC) : 1;
  localparam logic [TMR_W-1:0] c_ack_to    = TMR_W'(ACK_TIMEOUT_CYC);
  localparam logic [ALV_W-1:0] c_alive_end = ALV_W'(ALIVE_CYC - 1);
  localparam logic [1:0]       c_max_retry = 2'(MAX_RETRY);

  logic       w_tx_load, w_tx_busy, w_tx_done;
  logic [7:0] w_rx_data;
  logic       w_rx_valid, w_rx_ferr;

  host_state_e      state_q;
  logic [2:0]       code_q;
  logic [1:0]       retry_q;
  logic [TMR_W-1:0] ack_tmr_q;
  logic             cmd_ready_q, cmd_done_q, cmd_error_q;
  logic             reached_q, state_valid_q, alive_q;
  logic [7:0]       state_msg_q;
  logic [ALV_W-1:0] alive_cnt_q;
  logic             w_ack;

  assign w_tx_load = (state_q == H_SEND) && !w_tx_busy;
  assign w_ack     = w_rx_valid && (w_rx_data == c_ascii_ack) && (state_q == H_WAIT_ACK);

  uart_8n1_phy #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_phy (
    .clk            (clk),
    .reset_n        (reset_n),
    .tx_load_i      (w_tx_load),
    .tx_data_i      (code_to_ascii(code_q)),
    .tx_o           (tx),
    .tx_busy_o      (w_tx_busy),
    .tx_done_o      (w_tx_done),
    .rx_i           (rx),
    .rx_data_o      (w_rx_data),
    .rx_valid_o     (w_rx_valid),
    .rx_frame_err_o (w_rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= H_IDLE;
      code_q      <= 3'd0;
      retry_q     <= 2'd0;
      ack_tmr_q   <= '0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      cmd_done_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      case (state_q)
        H_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            retry_q <= 2'd0;
            if (code_to_ascii(cmd_code) == 8'h00) begin
              cmd_error_q <= 1'b1;
            end else begin
              code_q      <= cmd_code;
              cmd_ready_q <= 1'b0;
              state_q     <= H_SEND;
            end
          end
        end
        H_SEND: if (!w_tx_busy) state_q <= H_WAIT_TX;
        H_WAIT_TX: begin
          if (w_tx_done) begin
            ack_tmr_q <= '0;
            state_q   <= H_WAIT_ACK;
          end
        end
        H_WAIT_ACK: begin
          // An ack landing on the timeout cycle still completes the command
          if (w_ack) begin
            cmd_done_q  <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= H_IDLE;
          end else if (ack_tmr_q == c_ack_to) begin
            if (retry_q < c_max_retry) begin
              retry_q <= retry_q + 2'd1;
              state_q <= H_SEND;
            end else begin
              cmd_error_q <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= H_IDLE;
            end
          end else begin
            ack_tmr_q <= ack_tmr_q + 1'b1;
          end
        end
        default: state_q <= H_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reached_q     <= 1'b0;
      state_valid_q <= 1'b0;
      state_msg_q   <= 8'h00;
      alive_q       <= 1'b0;
      alive_cnt_q   <= '0;
    end else begin
      reached_q     <= w_rx_valid && (w_rx_data == c_ascii_reached);
      state_valid_q <= 1'b0;
      if (w_rx_valid && (w_rx_data != c_ascii_ack) && (w_rx_data != c_ascii_reached)) begin
        state_valid_q <= 1'b1;
        state_msg_q   <= w_rx_data;
      end
      if (w_rx_valid) begin
        alive_q     <= 1'b1;
        alive_cnt_q <= '0;
      end else if (alive_q) begin
        if (alive_cnt_q == c_alive_end) alive_q <= 1'b0;
        else                            alive_cnt_q <= alive_cnt_q + 1'b1;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign cmd_done      = cmd_done_q;
  assign cmd_error     = cmd_error_q;
  assign retry_cnt     = retry_q;
  assign reached_pulse = reached_q;
  assign state_valid   = state_valid_q;
  assign state_msg     = state_msg_q;
  assign link_alive    = alive_q;

endmodule

`default_nettype wire
